// File: rtl/dm_access_master_pkg.sv
// Shared definitions for the data-memory access master: op codes, FSM states,
// byte-enable masks and small lane helpers.
package dm_access_master_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    function automatic logic is_store(op_type_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Words need offset 0, halves need an even offset, bytes go anywhere.
    function automatic logic is_misaligned(op_type_e op, logic [1:0] off);
        case (op)
            OP_LW, OP_SW:         return off != 2'b00;
            OP_LH, OP_LHU, OP_SH: return off[0];
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(op_type_e op, logic [1:0] off);
        case (op)
            OP_LW, OP_SW:         return BE_WORD;
            OP_LH, OP_LHU, OP_SH: return BE_HALF << off;
            default:              return BE_BYTE << off;
        endcase
    endfunction

    // Replicating the store data means every lane carries the right bytes,
    // so the memory only has to honour the byte enables.
    function automatic logic [31:0] replicate_wdata(op_type_e op, logic [31:0] wdata);
        case (op)
            OP_SB:   return {4{wdata[7:0]}};
            OP_SH:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/dm_access_master_if.sv
// Op-side and bus-side signals of the data-memory access master.
// master = the access master itself, slave = pipeline + memory environment.
interface dm_access_master_if;

    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_type;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [31:0] op_pc;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        st_done;
    logic        err_align;
    logic        err_tmo;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_pc;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        input  op_valid, op_type, op_addr, op_wdata, op_pc, bus_ack, bus_rdata,
        output op_ready, stall, rd_valid, rd_data, st_done, err_align, err_tmo,
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_pc
    );

    modport slave (
        output op_valid, op_type, op_addr, op_wdata, op_pc, bus_ack, bus_rdata,
        input  op_ready, stall, rd_valid, rd_data, st_done, err_align, err_tmo,
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_pc
    );

endinterface

// File: rtl/dm_load_extend.sv
// Selects the addressed byte/half lane of a memory word and sign- or
// zero-extends it according to the load type.
module dm_load_extend
    import dm_access_master_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  op_type_e    op_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension; anything not a sub-word load passes the word.
    always_comb begin
        byte_sel = word_i[8*off_i +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (op_i)
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {24'h0, byte_sel};
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dm_access_master.sv
// Data-memory access master: takes one load/store at a time, issues a
// word-aligned bus request with byte enables, waits for ack (or times out)
// and returns extended load data.
// Optional: define DM_ACCESS_TRACE_EN to print a line for every acknowledged store.
module dm_access_master
    import dm_access_master_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
)
(
    input  logic               clk,
    input  logic               reset,
    dm_access_master_if.master dm
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    op_type_e           op_q;
    logic [1:0]         off_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        pc_q;
    logic [31:0]        rd_data_q;
    logic               err_tmo_q;

    logic               accept;
    logic               tmo;
    logic               load_ack;
    op_type_e           op_in;
    logic [31:0]        ext_data;

    assign op_in = op_type_e'(dm.op_type);

    // Next-state logic: accept in IDLE, wait for ack or timeout in REQ.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        tmo      = 1'b0;
        load_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dm.op_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = is_misaligned(op_in, dm.op_addr[1:0]) ? ST_ERR : ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack on the limit cycle still completes the op.
                if (dm.bus_ack) begin
                    load_ack = !we_q;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and timeout pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_tmo_q <= tmo;
        end
    end

    // Latch the op fields into the bus-facing registers on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= OP_LB;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            pc_q    <= 32'h0;
        end else if (accept) begin
            op_q    <= op_in;
            off_q   <= dm.op_addr[1:0];
            we_q    <= is_store(op_in);
            be_q    <= byte_enables(op_in, dm.op_addr[1:0]);
            addr_q  <= {dm.op_addr[31:2], 2'b00};
            wdata_q <= replicate_wdata(op_in, dm.op_wdata);
            pc_q    <= dm.op_pc;
        end
    end

    dm_load_extend u_load_extend (
        .word_i (dm.bus_rdata),
        .off_i  (off_q),
        .op_i   (op_q),
        .data_o (ext_data)
    );

    // Load data is extended as it arrives and held until the next load returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= 32'h0;
        end else if (load_ack) begin
            rd_data_q <= ext_data;
        end
    end

`ifdef DM_ACCESS_TRACE_EN
    // Trace each acknowledged store with only its enabled lanes visible.
    always_ff @(posedge clk) begin
        if (state_q == ST_REQ && dm.bus_ack && we_q) begin
            $display("@%h: *%h <= %h", pc_q, addr_q, wdata_q & lane_mask(be_q));
        end
    end
`endif

    assign dm.op_ready  = (state_q == ST_IDLE);
    assign dm.stall     = (state_q != ST_IDLE) || dm.op_valid;
    assign dm.bus_req   = (state_q == ST_REQ);
    assign dm.bus_we    = we_q;
    assign dm.bus_be    = be_q;
    assign dm.bus_addr  = addr_q;
    assign dm.bus_wdata = wdata_q;
    assign dm.bus_pc    = pc_q;
    assign dm.rd_valid  = (state_q == ST_RESP) && !we_q;
    assign dm.st_done   = (state_q == ST_RESP) && we_q;
    assign dm.rd_data   = rd_data_q;
    assign dm.err_align = (state_q == ST_ERR);
    assign dm.err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_dm_access_master.sv
// Self-checking bench for dm_access_master with a behavioural reference model.
module tb_dm_access_master;
    import dm_access_master_pkg::*;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_rd = 32'h0;

    dm_access_master_if dif();

    dm_access_master #(.TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .reset (rst_n),
        .dm    (dif)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int op_size(op_type_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 4;
        endcase
    endfunction

    function automatic bit op_st(op_type_e op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [3:0] m_be(op_type_e op, logic [31:0] addr);
        int s;
        s = op_size(op);
        if (s == 4) return 4'hF;
        return 4'(((1 << s) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(op_type_e op, logic [31:0] w);
        int s;
        s = op_size(op);
        if (s == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (s == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(op_type_e op, logic [31:0] addr, logic [31:0] r);
        int s;
        logic [31:0] v;
        s = op_size(op);
        v = r >> (8 * (addr % 4));
        if (s == 1) begin
            v = v & 32'hFF;
            if (op == OP_LB && v >= 128) v = v - 256;
        end else if (s == 2) begin
            v = v & 32'hFFFF;
            if (op == OP_LH && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    // Drives one op starting in the current IDLE cycle and follows it to the
    // first IDLE cycle afterwards. ack_dly = REQ cycle index of the ack, -1 = none.
    task automatic run_op(input op_type_e op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc, input int ack_dly, input logic [31:0] rdata,
                          input string tag);
        bit mis;
        bit st;
        bit acked;
        logic [31:0] exp_ld;
        mis   = (addr % op_size(op)) != 0;
        st    = op_st(op);
        acked = 1'b0;
        dif.op_valid = 1'b1;
        dif.op_type  = op;
        dif.op_addr  = addr;
        dif.op_wdata = wdata;
        dif.op_pc    = pc;
        #1;
        checks++;
        if (dif.op_ready !== 1'b1 || dif.stall !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: ready/stall got %b%b want 11", tag, dif.op_ready, dif.stall);
        end
        @(negedge clk);
        dif.op_valid = 1'b0;
        dif.op_type  = 3'($urandom);
        dif.op_addr  = $urandom;
        dif.op_wdata = $urandom;
        dif.op_pc    = $urandom;
        #1;
        if (mis) begin
            checks++;
            if ({dif.err_align, dif.bus_req, dif.op_ready, dif.stall} !== 4'b1001) begin
                errors++;
                $display("FAIL %s align: err/req/ready/stall got %b%b%b%b want 1001", tag,
                         dif.err_align, dif.bus_req, dif.op_ready, dif.stall);
            end
            @(negedge clk);
            #1;
            checks++;
            if ({dif.err_align, dif.bus_req, dif.op_ready, dif.stall} !== 4'b0010) begin
                errors++;
                $display("FAIL %s align_after: err/req/ready/stall got %b%b%b%b want 0010", tag,
                         dif.err_align, dif.bus_req, dif.op_ready, dif.stall);
            end
            return;
        end
        for (int k = 0; k < TMO; k++) begin
            dif.bus_ack   = (k == ack_dly);
            dif.bus_rdata = (k == ack_dly) ? rdata : $urandom;
            #1;
            checks++;
            if (dif.bus_req !== 1'b1 || dif.bus_we !== st || dif.bus_be !== m_be(op, addr) ||
                dif.bus_addr !== (addr & ~32'h3) || dif.bus_pc !== pc ||
                (st && dif.bus_wdata !== m_wdata(op, wdata)) || dif.stall !== 1'b1 ||
                dif.op_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s req[%0d]: req=%b we=%b be=%b addr=%h wd=%h pc=%h want req=1 we=%b be=%b addr=%h wd=%h pc=%h",
                         tag, k, dif.bus_req, dif.bus_we, dif.bus_be, dif.bus_addr, dif.bus_wdata,
                         dif.bus_pc, st, m_be(op, addr), addr & ~32'h3, m_wdata(op, wdata), pc);
            end
            @(negedge clk);
            if (k == ack_dly) begin
                acked = 1'b1;
                break;
            end
        end
        dif.bus_ack = 1'b0;
        #1;
        if (acked) begin
            if (!st) last_rd = m_load(op, addr, rdata);
            exp_ld = last_rd;
            checks++;
            if (dif.st_done !== st || dif.rd_valid !== !st || dif.stall !== 1'b1 ||
                dif.op_ready !== 1'b0 || dif.bus_req !== 1'b0 || dif.rd_data !== exp_ld) begin
                errors++;
                $display("FAIL %s resp: st_done=%b rd_valid=%b stall=%b req=%b rd=%h want %b %b 1 0 %h",
                         tag, dif.st_done, dif.rd_valid, dif.stall, dif.bus_req, dif.rd_data,
                         st, !st, exp_ld);
            end
            @(negedge clk);
            #1;
            checks++;
            if (dif.st_done !== 1'b0 || dif.rd_valid !== 1'b0 || dif.stall !== 1'b0 ||
                dif.op_ready !== 1'b1 || dif.rd_data !== exp_ld) begin
                errors++;
                $display("FAIL %s idle: st_done=%b rd_valid=%b stall=%b ready=%b rd=%h want 0 0 0 1 %h",
                         tag, dif.st_done, dif.rd_valid, dif.stall, dif.op_ready, dif.rd_data, exp_ld);
            end
        end else begin
            checks++;
            if (dif.bus_req !== 1'b0 || dif.err_tmo !== 1'b1 || dif.op_ready !== 1'b1 ||
                dif.st_done !== 1'b0 || dif.rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s tmo: req=%b err_tmo=%b ready=%b want 0 1 1", tag,
                         dif.bus_req, dif.err_tmo, dif.op_ready);
            end
            @(negedge clk);
            #1;
            checks++;
            if (dif.err_tmo !== 1'b0 || dif.bus_req !== 1'b0) begin
                errors++;
                $display("FAIL %s tmo_after: err_tmo=%b req=%b want 0 0", tag, dif.err_tmo, dif.bus_req);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({dif.op_ready, dif.stall, dif.rd_valid, dif.st_done, dif.err_align, dif.err_tmo,
             dif.bus_req, dif.bus_we} !== 8'b1000_0000 ||
            dif.bus_be !== 4'h0 || dif.bus_addr !== 32'h0 || dif.bus_wdata !== 32'h0 ||
            dif.bus_pc !== 32'h0 || dif.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset: ready=%b stall=%b req=%b be=%b addr=%h rd=%h want ready=1 rest 0",
                     dif.op_ready, dif.stall, dif.bus_req, dif.bus_be, dif.bus_addr, dif.rd_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (dif.op_ready !== 1'b1 || dif.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b req=%b want 1 0", dif.op_ready, dif.bus_req);
        end
    endtask

    task automatic test_store();
        run_op(OP_SW, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_1000, 0, 32'h0, "sw");
        run_op(OP_SB, 32'h0000_0011, 32'h0000_00A5, 32'h0000_1004, 2, 32'h0, "sb");
    endtask

    task automatic test_load_byte();
        run_op(OP_LB, 32'h0000_0013, 32'h0, 32'h0000_2000, 1, 32'h80AB_CDEF, "lb");
        checks++;
        if (dif.rd_data !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_value: got %h want ffffff80", dif.rd_data);
        end
        run_op(OP_LBU, 32'h0000_0013, 32'h0, 32'h0000_2004, 0, 32'h80AB_CDEF, "lbu");
        checks++;
        if (dif.rd_data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu_value: got %h want 00000080", dif.rd_data);
        end
        run_op(OP_LH, 32'h0000_0012, 32'h0, 32'h0000_2008, 0, 32'h80AB_CDEF, "lh");
        run_op(OP_LHU, 32'h0000_0012, 32'h0, 32'h0000_200C, 3, 32'h80AB_CDEF, "lhu");
        run_op(OP_LW, 32'h0000_0014, 32'h0, 32'h0000_2010, 0, 32'h1357_9BDF, "lw");
    endtask

    task automatic test_align();
        run_op(OP_LH, 32'h0000_0011, 32'h0, 32'h0000_3000, 0, 32'h0, "lh_mis");
        run_op(OP_SW, 32'h0000_0022, 32'h0, 32'h0000_3004, 0, 32'h0, "sw_mis");
    endtask

    task automatic test_timeout();
        run_op(OP_LW, 32'h0000_0020, 32'h0, 32'h0000_4000, -1, 32'h0, "lw_tmo");
        run_op(OP_SW, 32'h0000_0024, 32'h0BAD_F00D, 32'h0000_4004, TMO - 1, 32'h0, "sw_ack_at_limit");
    endtask

    task automatic test_reset_mid_req();
        run_op(OP_SH, 32'h0000_0006, 32'h1234_5678, 32'h0000_5000, 4, 32'h0, "sh");
        dif.op_valid = 1'b1;
        dif.op_type  = OP_SH;
        dif.op_addr  = 32'h0000_0006;
        dif.op_wdata = 32'h1234_5678;
        dif.op_pc    = 32'h0000_5004;
        @(negedge clk);
        dif.op_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (dif.bus_req !== 1'b1 || dif.bus_be !== 4'b1100 || dif.bus_wdata !== 32'h5678_5678) begin
            errors++;
            $display("FAIL sh_mid: req=%b be=%b wd=%h want 1 1100 56785678",
                     dif.bus_req, dif.bus_be, dif.bus_wdata);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dif.bus_req !== 1'b0 || dif.op_ready !== 1'b1 || dif.stall !== 1'b0 ||
            dif.st_done !== 1'b0 || dif.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: req=%b ready=%b stall=%b st_done=%b rd=%h want 0 1 0 0 0",
                     dif.bus_req, dif.op_ready, dif.stall, dif.st_done, dif.rd_data);
        end
        last_rd = 32'h0;
        @(negedge clk);
        rst_n       = 1'b1;
        dif.bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (dif.st_done !== 1'b0 || dif.bus_req !== 1'b0 || dif.err_tmo !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after[%0d]: st_done=%b req=%b err_tmo=%b want 0 0 0",
                         i, dif.st_done, dif.bus_req, dif.err_tmo);
            end
        end
        dif.bus_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_op(OP_SB, 32'h0000_0003, 32'h0000_00C3, 32'h0000_6000, 0, 32'h0, "b2b_sb");
        run_op(OP_LW, 32'h0000_0000, 32'h0, 32'h0000_6004, 0, 32'hCAFE_F00D, "b2b_lw");
        run_op(OP_LB, 32'h0000_0001, 32'h0, 32'h0000_6008, 0, 32'hCAFE_F00D, "b2b_lb");
    endtask

    task automatic test_stray_ack();
        dif.bus_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (dif.bus_req !== 1'b0 || dif.st_done !== 1'b0 || dif.rd_valid !== 1'b0 ||
                dif.op_ready !== 1'b1 || dif.rd_data !== last_rd) begin
                errors++;
                $display("FAIL stray_ack[%0d]: req=%b st_done=%b rd_valid=%b ready=%b rd=%h want 0 0 0 1 %h",
                         i, dif.bus_req, dif.st_done, dif.rd_valid, dif.op_ready, dif.rd_data, last_rd);
            end
        end
        dif.bus_ack = 1'b0;
    endtask

    task automatic test_random();
        op_type_e op;
        int dly;
        for (int n = 0; n < 60; n++) begin
            op  = op_type_e'($urandom_range(0, 7));
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            run_op(op, $urandom, $urandom, $urandom, dly, $urandom, "rand");
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    initial begin
        dif.op_valid  = 1'b0;
        dif.op_type   = OP_LW;
        dif.op_addr   = 32'h0;
        dif.op_wdata  = 32'h0;
        dif.op_pc     = 32'h0;
        dif.bus_ack   = 1'b0;
        dif.bus_rdata = 32'h0;
        rst_n         = 1'b0;
        test_reset();
        test_store();
        test_load_byte();
        test_align();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        test_stray_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
